// File: rtl/calc_op_sequencer_if.sv
//------------------------------------------------------------------------------
// calc_op_sequencer_if
// Accumulator / converter / display command bus of the calculator sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface calc_op_sequencer_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [15:0] op_operand;
    logic        op_ready;
    logic        conv_start;
    logic        conv_done;
    logic        disp_load;

    modport master (
        output op_valid, op_code, op_operand, conv_start, disp_load,
        input  op_ready, conv_done
    );

    modport slave (
        input  op_valid, op_code, op_operand, conv_start, disp_load,
        output op_ready, conv_done
    );
endinterface

`default_nettype wire

// File: rtl/calc_op_sequencer.sv
//------------------------------------------------------------------------------
// calc_op_sequencer
// Debounces the five push-buttons, queues one request per press and sequences
// accumulator op -> BCD conversion -> display load. Optional macro
// AUTO_REPEAT_EN adds hold-to-repeat on BTNL/BTNR.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module calc_op_sequencer #(
    parameter int DEBOUNCE_W = 20,
    parameter int CONV_TO_W  = 8,
    parameter int REPEAT_W   = 23
) (
    input  wire                 clk,
    input  wire                 rstn,
    input  wire                 BTNC,
    input  wire                 BTNL,
    input  wire                 BTNR,
    input  wire                 BTNU,
    input  wire                 BTND,
    input  wire  [15:0]         slideSW_in,
    calc_op_sequencer_if.master bus,
    output logic                busy,
    output logic                err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CONVERT = 2'd2,
        S_LOAD    = 2'd3
    } state_t;

    localparam int c_NBTN = 5;

    // Bit order C, L, R, U, D: lower index means higher grant priority.
    logic [c_NBTN-1:0]     w_btn_raw;
    logic [c_NBTN-1:0]     r_sync1;
    logic [c_NBTN-1:0]     r_sync2;
    logic [c_NBTN-1:0]     r_stable;
    logic [c_NBTN-1:0]     r_pending;
    logic [c_NBTN-1:0]     w_rise;
    logic [c_NBTN-1:0]     w_repeat;
    logic [c_NBTN-1:0]     w_grant;
    logic [c_NBTN-1:0]     w_pending_nxt;
    logic [DEBOUNCE_W-1:0] r_db_cnt [c_NBTN];

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_code;
    logic [2:0]            w_grant_code;
    logic [15:0]           r_operand;
    logic                  r_conv_start;
    logic                  r_err;
    logic                  w_timeout;
    logic [CONV_TO_W-1:0]  r_to_cnt;

    assign w_btn_raw = {BTND, BTNU, BTNR, BTNL, BTNC};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only advances while the synchronized level disagrees with the
    // accepted level, so any bounce back restarts the qualification window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stable <= '0;
            for (int i = 0; i < c_NBTN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NBTN; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (&r_db_cnt[i]) begin
                    r_db_cnt[i] <= '0;
                    r_stable[i] <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rise = '0;
        for (int i = 0; i < c_NBTN; i++) begin
            w_rise[i] = r_sync2[i] & ~r_stable[i] & (&r_db_cnt[i]);
        end
    end

`ifdef AUTO_REPEAT_EN
    logic [REPEAT_W-1:0] r_rep_cnt [2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rep_cnt[0] <= '0;
            r_rep_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!r_stable[i+1] || w_rise[i+1]) begin
                    r_rep_cnt[i] <= '0;
                end else begin
                    r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_repeat    = '0;
        w_repeat[1] = r_stable[1] & (&r_rep_cnt[0]);
        w_repeat[2] = r_stable[2] & (&r_rep_cnt[1]);
    end
`else
    assign w_repeat = '0;
`endif

    // A new press landing on the grant edge survives as a fresh request.
    assign w_pending_nxt = (r_pending & ~w_grant) | w_rise | w_repeat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = '0;
        w_grant_code = 3'd0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pending) begin
                    w_state_nxt = S_ISSUE;
                    for (int i = c_NBTN - 1; i >= 0; i--) begin
                        if (r_pending[i]) begin
                            w_grant      = '0;
                            w_grant[i]   = 1'b1;
                            w_grant_code = 3'(i + 1);
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (bus.op_ready) begin
                    w_state_nxt = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (bus.conv_done) begin
                    w_state_nxt = S_LOAD;
                end else if (&r_to_cnt) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending    <= '0;
            r_code       <= 3'd0;
            r_operand    <= 16'd0;
            r_conv_start <= 1'b0;
            r_to_cnt     <= '0;
            r_err        <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (|w_grant) begin
                r_code    <= w_grant_code;
                r_operand <= slideSW_in;
            end
            r_conv_start <= (r_state == S_ISSUE) && bus.op_ready;
            r_to_cnt     <= (r_state == S_CONVERT) ? r_to_cnt + 1'b1 : '0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.op_valid   = (r_state == S_ISSUE);
    assign bus.op_code    = (r_state == S_ISSUE) ? r_code : 3'd0;
    assign bus.op_operand = r_operand;
    assign bus.conv_start = r_conv_start;
    assign bus.disp_load  = (r_state == S_LOAD);
    assign busy           = (r_state != S_IDLE);
    assign err            = r_err;

endmodule

`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
//------------------------------------------------------------------------------
// tb_calc_op_sequencer
// Self-checking bench: button presses against a priority-queue request model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_calc_op_sequencer;

    localparam int DBW = 4;
    localparam int TOW = 4;
    localparam int RPW = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        btnc, btnl, btnr, btnu, btnd;
    logic [15:0] sw;
    logic        busy, err;

    int checks   = 0;
    int failures = 0;
    int ready_stall = 0;
    int conv_delay  = 0;

    // Monitor state
    int         cyc = 0;
    int         n_valid, n_start, n_disp, stall_viol, idle_code_viol;
    int         t_first_valid, t_disp, t_start, t_err;
    logic [2:0] got_code [$];
    logic [15:0] got_opnd [$];
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [2:0] prev_code = 3'd0;
    logic [15:0] prev_opnd = 16'd0;

    // Priority table: button index C,L,R,U,D -> operation code
    int code_of [5] = '{1, 2, 3, 4, 5};

    calc_op_sequencer_if bus();

    calc_op_sequencer #(
        .DEBOUNCE_W (DBW),
        .CONV_TO_W  (TOW),
        .REPEAT_W   (RPW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .BTNC       (btnc),
        .BTNL       (btnl),
        .BTNR       (btnr),
        .BTNU       (btnu),
        .BTND       (btnd),
        .slideSW_in (sw),
        .bus        (bus),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Accumulator / converter responder
    initial begin : responder
        int vcnt;
        int cd;
        vcnt = 0;
        cd   = -1;
        bus.op_ready  = 1'b0;
        bus.conv_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                vcnt = 0;
                cd   = -1;
                bus.op_ready  = 1'b0;
                bus.conv_done = 1'b0;
            end else begin
                if (bus.op_valid) begin
                    bus.op_ready = (vcnt >= ready_stall);
                    vcnt = bus.op_ready ? 0 : vcnt + 1;
                end else begin
                    bus.op_ready = (ready_stall == 0);
                    vcnt = 0;
                end
                if (bus.conv_start) cd = conv_delay;
                bus.conv_done = (cd == 0);
                if (cd >= 0) cd--;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (rstn) begin
                if (bus.op_valid) begin
                    n_valid++;
                    if (t_first_valid < 0) t_first_valid = cyc;
                    if (prev_valid && !prev_ready &&
                        (bus.op_code !== prev_code || bus.op_operand !== prev_opnd))
                        stall_viol++;
                    if (bus.op_ready) begin
                        got_code.push_back(bus.op_code);
                        got_opnd.push_back(bus.op_operand);
                    end
                end else if (bus.op_code !== 3'd0) begin
                    idle_code_viol++;
                end
                if (bus.conv_start) begin
                    n_start++;
                    t_start = cyc;
                end
                if (bus.disp_load) begin
                    n_disp++;
                    if (t_disp < 0) t_disp = cyc;
                end
                if (err && t_err < 0) t_err = cyc;
            end
            prev_valid = bus.op_valid;
            prev_ready = bus.op_ready;
            prev_code  = bus.op_code;
            prev_opnd  = bus.op_operand;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btns(input logic [4:0] m);
        btnc = m[0]; btnl = m[1]; btnr = m[2]; btnu = m[3]; btnd = m[4];
    endtask

    task automatic press(input logic [4:0] m, input int hold);
        set_btns(m);
        tick(hold);
        set_btns(5'd0);
    endtask

    task automatic clear_mon();
        n_valid = 0; n_start = 0; n_disp = 0; stall_viol = 0; idle_code_viol = 0;
        t_first_valid = -1; t_disp = -1; t_start = -1; t_err = -1;
        got_code.delete();
        got_opnd.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        set_btns(5'd0);
        ready_stall = 0;
        conv_delay  = 0;
        tick(3);
        rstn = 1'b1;
        tick(2);
        clear_mon();
    endtask

    task automatic drain(input int budget, input string name);
        int idle_run = 0;
        int n = 0;
        while (idle_run < 40 && n < budget) begin
            tick(1);
            n++;
            idle_run = busy ? 0 : idle_run + 1;
        end
        checks++;
        if (idle_run < 40) begin
            failures++;
            $display("FAIL %s_drain: busy=%0b after %0d cycles, required idle", name, busy, budget);
        end
    endtask

    task automatic test_reset();
        sw = 16'hFFFF;
        rstn = 1'b0;
        set_btns(5'($urandom_range(1, 31)));
        tick(4);
        checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid: got %0b want 0", bus.op_valid); end
        checks++; if (bus.op_code !== 3'd0) begin failures++; $display("FAIL reset_op_code: got %0d want 0", bus.op_code); end
        checks++; if (bus.op_operand !== 16'd0) begin failures++; $display("FAIL reset_op_operand: got %0d want 0", bus.op_operand); end
        checks++; if ({bus.conv_start, bus.disp_load} !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b want 00", {bus.conv_start, bus.disp_load}); end
        checks++; if ({busy, err} !== 2'b00) begin failures++; $display("FAIL reset_busy_err: got %b want 00", {busy, err}); end
        do_reset();
    endtask

    task automatic test_load();
        do_reset();
        sw = 16'd12345;
        conv_delay = 2;
        press(5'b00001, 40);
        drain(500, "load");
        checks++; if (got_code.size() != 1) begin failures++; $display("FAIL load_count: got %0d ops want 1", got_code.size()); end
        if (got_code.size() > 0) begin
            checks++; if (got_code[0] !== 3'd1) begin failures++; $display("FAIL load_code: got %0d want 1", got_code[0]); end
            checks++; if (got_opnd[0] !== 16'd12345) begin failures++; $display("FAIL load_operand: got %0d want 12345", got_opnd[0]); end
        end
        checks++; if (n_start != 1 || n_disp != 1) begin failures++; $display("FAIL load_pulses: got start=%0d disp=%0d want 1/1", n_start, n_disp); end
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL load_idle: got busy=%0b err=%0b want 0/0", busy, err); end
    endtask

    task automatic test_latency();
        clear_mon();
        conv_delay  = 0;
        ready_stall = 0;
        press(5'b01000, 24);
        drain(500, "latency");
        checks++; if (t_disp - t_first_valid != 2) begin failures++; $display("FAIL latency: got %0d cycles valid->disp_load want 2", t_disp - t_first_valid); end
        checks++; if (n_valid != 1 || n_disp != 1) begin failures++; $display("FAIL latency_single: got valid=%0d disp=%0d want 1/1", n_valid, n_disp); end
    endtask

    task automatic test_glitch();
        clear_mon();
        repeat (10) begin
            press(5'b00001, 3);
            tick(3);
        end
        tick(40);
        checks++; if (n_valid != 0 || got_code.size() != 0) begin failures++; $display("FAIL glitch: got valid_cycles=%0d ops=%0d want 0/0", n_valid, got_code.size()); end
    endtask

    task automatic test_priority();
        int exp_q [$];
        logic [4:0] m;
        clear_mon();
        m = 5'b11010;
        ready_stall = 5;
        conv_delay  = $urandom_range(0, 3);
        for (int b = 0; b < 5; b++) if (m[b]) exp_q.push_back(code_of[b]);
        press(m, 30);
        drain(1000, "priority");
        checks++; if (got_code.size() != exp_q.size()) begin failures++; $display("FAIL priority_count: got %0d ops want %0d", got_code.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_code.size(); k++) begin
            checks++; if (int'(got_code[k]) != exp_q[k]) begin failures++; $display("FAIL priority_order[%0d]: got %0d want %0d", k, got_code[k], exp_q[k]); end
        end
        checks++; if (n_valid != 3 * (ready_stall + 1)) begin failures++; $display("FAIL priority_stall_cycles: got %0d want %0d", n_valid, 3 * (ready_stall + 1)); end
        checks++; if (stall_viol != 0 || idle_code_viol != 0) begin failures++; $display("FAIL priority_hold: got stall_changes=%0d idle_codes=%0d want 0/0", stall_viol, idle_code_viol); end
        checks++; if (n_disp != 3) begin failures++; $display("FAIL priority_disp: got %0d want 3", n_disp); end
        ready_stall = 0;
    endtask

    task automatic test_busy_collapse();
        clear_mon();
        ready_stall = 120;
        conv_delay  = 1;
        press(5'b00001, 24);
        press(5'b00100, 24);
        tick(24);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL collapse_busy: got busy=%0b want 1", busy); end
        press(5'b00100, 24);
        drain(1500, "collapse");
        checks++; if (got_code.size() != 2) begin failures++; $display("FAIL collapse_count: got %0d ops want 2", got_code.size()); end
        if (got_code.size() == 2) begin
            checks++; if (got_code[0] !== 3'd1 || got_code[1] !== 3'd3) begin failures++; $display("FAIL collapse_codes: got %0d,%0d want 1,3", got_code[0], got_code[1]); end
        end
        ready_stall = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int exp_q [$];
            logic [4:0] m;
            logic [15:0] v;
            clear_mon();
            m = 5'($urandom_range(1, 31));
            v = 16'($urandom);
            sw = v;
            ready_stall = $urandom_range(0, 3);
            conv_delay  = $urandom_range(0, 4);
            for (int b = 0; b < 5; b++) if (m[b]) exp_q.push_back(code_of[b]);
            press(m, 24);
            drain(1000, "random");
            checks++; if (got_code.size() != exp_q.size()) begin failures++; $display("FAIL random%0d_count: mask=%b got %0d ops want %0d", it, m, got_code.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < got_code.size(); k++) begin
                checks++;
                if (int'(got_code[k]) != exp_q[k] || got_opnd[k] !== v) begin
                    failures++;
                    $display("FAIL random%0d_op[%0d]: got code=%0d opnd=%0d want code=%0d opnd=%0d", it, k, got_code[k], got_opnd[k], exp_q[k], v);
                end
            end
            checks++; if (n_disp != exp_q.size() || n_valid != exp_q.size() * (ready_stall + 1)) begin failures++; $display("FAIL random%0d_cycles: got disp=%0d valid=%0d want %0d/%0d", it, n_disp, n_valid, exp_q.size(), exp_q.size() * (ready_stall + 1)); end
        end
        ready_stall = 0;
        conv_delay  = 0;
    endtask

    task automatic test_timeout();
        clear_mon();
        conv_delay = -1;
        press(5'b00010, 24);
        drain(500, "timeout");
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_err: got %0b want 1", err); end
        checks++; if (t_err - t_start != 16) begin failures++; $display("FAIL timeout_delay: got %0d cycles want 16", t_err - t_start); end
        checks++; if (n_disp != 0 || n_start != 1) begin failures++; $display("FAIL timeout_pulses: got disp=%0d start=%0d want 0/1", n_disp, n_start); end
        clear_mon();
        conv_delay = 2;
        press(5'b01000, 24);
        drain(500, "after_timeout");
        checks++; if (got_code.size() != 1 || (got_code.size() == 1 && got_code[0] !== 3'd4)) begin failures++; $display("FAIL after_timeout_op: got %0d ops want one code 4", got_code.size()); end
        checks++; if (err !== 1'b1 || n_disp != 1) begin failures++; $display("FAIL after_timeout_sticky: got err=%0b disp=%0d want 1/1", err, n_disp); end
        conv_delay = 0;
    endtask

    task automatic test_reset_abort();
        int n = 0;
        clear_mon();
        ready_stall = 50;
        set_btns(5'b00011);
        while (!bus.op_valid && n < 60) begin
            tick(1);
            n++;
        end
        checks++; if (bus.op_valid !== 1'b1) begin failures++; $display("FAIL abort_issue: got op_valid=%0b want 1", bus.op_valid); end
        rstn = 1'b0;
        set_btns(5'd0);
        #1;
        checks++; if ({bus.op_valid, busy, err, bus.op_code} !== 6'd0) begin failures++; $display("FAIL abort_clear: got valid/busy/err/code=%b want 0", {bus.op_valid, busy, err, bus.op_code}); end
        tick(2);
        rstn = 1'b1;
        ready_stall = 0;
        clear_mon();
        tick(60);
        checks++; if (n_valid != 0 || n_start != 0 || n_disp != 0) begin failures++; $display("FAIL abort_trailing: got valid=%0d start=%0d disp=%0d want 0/0/0", n_valid, n_start, n_disp); end
    endtask

    task automatic test_repeat();
        int exp_n;
        bit all_inc;
`ifdef AUTO_REPEAT_EN
        exp_n = 1 + 300 / (1 << RPW);
`else
        exp_n = 1;
`endif
        clear_mon();
        press(5'b00010, 300);
        drain(1000, "repeat");
        all_inc = 1'b1;
        foreach (got_code[k]) if (got_code[k] !== 3'd2) all_inc = 1'b0;
        checks++; if (got_code.size() != exp_n || !all_inc) begin failures++; $display("FAIL repeat_count: got %0d ops (all INC=%0b) want %0d INC", got_code.size(), all_inc, exp_n); end
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        set_btns(5'd0);
        sw = 16'd0;
        clear_mon();
        test_reset();
        test_load();
        test_latency();
        test_glitch();
        test_priority();
        test_busy_collapse();
        test_random();
        test_timeout();
        test_reset_abort();
        test_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
